// File: rtl/acc_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator datapath.
// Owns PC and IR and issues one cycle of datapath controls per instruction.
module acc_control_unit #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       CLB,
   input  logic       run,
   input  logic [7:0] progData,
   input  logic [7:0] Acc,
   output logic [7:0] progAddr,
   output logic       LoadAcc,
   output logic [1:0] SelAcc,
   output logic [3:0] imm,
   output logic [3:0] regSel,
   output logic       regWrite,
   output logic [2:0] aluOp,
   output logic       halted
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_DECODE = 2'd1,
      S_EXEC   = 2'd2,
      S_HALT   = 2'd3
   } state_t;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LDI = 4'h1,
      OP_MOV = 4'h2,
      OP_STR = 4'h3,
      OP_ADD = 4'h4,
      OP_SUB = 4'h5,
      OP_AND = 4'h6,
      OP_OR  = 4'h7,
      OP_XOR = 4'h8,
      OP_JMP = 4'h9,
      OP_JZ  = 4'hA,
      OP_HLT = 4'hF
   } opcode_t;

   localparam logic [1:0] SEL_IMM = 2'b00;
   localparam logic [1:0] SEL_REG = 2'b01;
   localparam logic [1:0] SEL_ALU = 2'b10;

   state_t     state, next_state;
   logic [7:0] pc;
   logic [7:0] ir;
   logic [3:0] opcode;
   logic       jump;

   assign opcode   = ir[7:4];
   assign imm      = ir[3:0];
   assign regSel   = ir[3:0];
   assign progAddr = pc;
   assign halted   = (state == S_HALT);

   // NOTE: registered state uses non-blocking assignments so every flop samples
   // the pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge clk) begin
      if (CLB) begin
         state <= S_FETCH;
         pc    <= RESET_PC;
         ir    <= 8'h00;
      end else begin
         state <= next_state;
         if (state == S_FETCH) begin
            ir <= progData;
            pc <= pc + 8'd1;
         end else if (jump) begin
            pc <= Acc;
         end
      end
   end

   // NOTE: every output is given a default before the case so no path through
   // this block leaves a signal unassigned, which would infer a latch.
   always_comb begin
      next_state = state;
      LoadAcc    = 1'b0;
      SelAcc     = SEL_IMM;
      aluOp      = 3'b000;
      regWrite   = 1'b0;
      jump       = 1'b0;

      case (state)
         S_FETCH:  next_state = S_DECODE;
         S_DECODE: next_state = S_EXEC;
         S_EXEC: begin
            next_state = (opcode == OP_HLT) ? S_HALT : S_FETCH;
            case (opcode)
               OP_LDI: begin LoadAcc = 1'b1; SelAcc = SEL_IMM; end
               OP_MOV: begin LoadAcc = 1'b1; SelAcc = SEL_REG; end
               OP_STR: regWrite = 1'b1;
               OP_ADD: begin LoadAcc = 1'b1; SelAcc = SEL_ALU; aluOp = 3'b000; end
               OP_SUB: begin LoadAcc = 1'b1; SelAcc = SEL_ALU; aluOp = 3'b001; end
               OP_AND: begin LoadAcc = 1'b1; SelAcc = SEL_ALU; aluOp = 3'b010; end
               OP_OR:  begin LoadAcc = 1'b1; SelAcc = SEL_ALU; aluOp = 3'b011; end
               OP_XOR: begin LoadAcc = 1'b1; SelAcc = SEL_ALU; aluOp = 3'b100; end
               OP_JMP: jump = 1'b1;
               // Zero test uses the accumulator as it stands during EXEC.
               OP_JZ:  jump = (Acc == 8'h00);
               default: ;
            endcase
         end
         S_HALT:   next_state = run ? S_FETCH : S_HALT;
         default:  next_state = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_acc_control_unit.sv
// Bench for acc_control_unit: directed vector table, corner sequences, and a
// random program run against an instruction-level model with a small datapath.
module tb_acc_control_unit;

   localparam logic [7:0] RPC = 8'h10;

   logic       clk = 1'b0;
   logic       CLB = 1'b0;
   logic       run = 1'b0;
   logic [7:0] progData;
   logic [7:0] Acc;
   logic [7:0] progAddr;
   logic       LoadAcc;
   logic [1:0] SelAcc;
   logic [3:0] imm;
   logic [3:0] regSel;
   logic       regWrite;
   logic [2:0] aluOp;
   logic       halted;

   logic [7:0] prog [256];
   logic       env_en = 1'b0;
   logic [7:0] forced_acc = 8'h00;
   logic [7:0] env_acc;
   logic [7:0] env_regs [16];

   int checks = 0;
   int errors = 0;

   acc_control_unit #(.RESET_PC(RPC)) dut (
      .clk(clk), .CLB(CLB), .run(run), .progData(progData), .Acc(Acc),
      .progAddr(progAddr), .LoadAcc(LoadAcc), .SelAcc(SelAcc), .imm(imm),
      .regSel(regSel), .regWrite(regWrite), .aluOp(aluOp), .halted(halted)
   );

   always #5 clk = ~clk;

   assign progData = prog[progAddr];
   assign Acc      = env_en ? env_acc : forced_acc;

   function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         default: return 8'h00;
      endcase
   endfunction

   // Environment datapath: accumulator and register file obeying the controls.
   always @(posedge clk) begin
      if (CLB) begin
         env_acc <= 8'h00;
         for (int i = 0; i < 16; i++) env_regs[i] <= 8'h00;
      end else begin
         if (LoadAcc) begin
            case (SelAcc)
               2'b00:   env_acc <= {4'b0, imm};
               2'b01:   env_acc <= env_regs[regSel];
               default: env_acc <= alu(aluOp, env_acc, env_regs[regSel]);
            endcase
         end
         if (regWrite) env_regs[regSel] <= env_acc;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_ctrl(input string tag, input logic l, input logic [1:0] s,
                             input logic [2:0] a, input logic w);
      check({tag, " LoadAcc"}, LoadAcc, l);
      check({tag, " SelAcc"}, SelAcc, s);
      check({tag, " aluOp"}, aluOp, a);
      check({tag, " regWrite"}, regWrite, w);
      if (LoadAcc && regWrite) check({tag, " load/write exclusive"}, 1, 0);
   endtask

   task automatic do_reset();
      CLB = 1'b1;
      tick();
      tick();
      CLB = 1'b0;
   endtask

   typedef struct {
      logic [7:0] instr;
      logic [7:0] acc;
      logic       load;
      logic [1:0] sel;
      logic [2:0] alu;
      logic       rw;
      logic [7:0] next_pc;
      logic       halt;
   } vec_t;

   vec_t vecs [15];

   // Instruction-level reference model state.
   logic [7:0] m_pc, m_acc;
   logic [7:0] m_regs [16];

   initial begin
      vecs[0]  = '{8'h00, 8'h00, 1'b0, 2'b00, 3'b000, 1'b0, 8'h11, 1'b0};
      vecs[1]  = '{8'h15, 8'h00, 1'b1, 2'b00, 3'b000, 1'b0, 8'h11, 1'b0};
      vecs[2]  = '{8'h27, 8'h33, 1'b1, 2'b01, 3'b000, 1'b0, 8'h11, 1'b0};
      vecs[3]  = '{8'h32, 8'h44, 1'b0, 2'b00, 3'b000, 1'b1, 8'h11, 1'b0};
      vecs[4]  = '{8'h42, 8'h01, 1'b1, 2'b10, 3'b000, 1'b0, 8'h11, 1'b0};
      vecs[5]  = '{8'h53, 8'h01, 1'b1, 2'b10, 3'b001, 1'b0, 8'h11, 1'b0};
      vecs[6]  = '{8'h64, 8'h01, 1'b1, 2'b10, 3'b010, 1'b0, 8'h11, 1'b0};
      vecs[7]  = '{8'h75, 8'h01, 1'b1, 2'b10, 3'b011, 1'b0, 8'h11, 1'b0};
      vecs[8]  = '{8'h86, 8'h01, 1'b1, 2'b10, 3'b100, 1'b0, 8'h11, 1'b0};
      vecs[9]  = '{8'h90, 8'h80, 1'b0, 2'b00, 3'b000, 1'b0, 8'h80, 1'b0};
      vecs[10] = '{8'hA0, 8'h00, 1'b0, 2'b00, 3'b000, 1'b0, 8'h00, 1'b0};
      vecs[11] = '{8'hA0, 8'h07, 1'b0, 2'b00, 3'b000, 1'b0, 8'h11, 1'b0};
      vecs[12] = '{8'hB1, 8'h00, 1'b0, 2'b00, 3'b000, 1'b0, 8'h11, 1'b0};
      vecs[13] = '{8'hE9, 8'h00, 1'b0, 2'b00, 3'b000, 1'b0, 8'h11, 1'b0};
      vecs[14] = '{8'hF0, 8'h00, 1'b0, 2'b00, 3'b000, 1'b0, 8'h11, 1'b1};

      for (int i = 0; i < 256; i++) prog[i] = 8'h00;
      tick();

      // Directed vectors: one instruction at RESET_PC, checked cycle by cycle.
      for (int i = 0; i < 15; i++) begin
         string t;
         t = $sformatf("vec%0d", i);
         prog[RPC] = vecs[i].instr;
         forced_acc = vecs[i].acc;
         do_reset();
         check({t, " reset progAddr"}, progAddr, RPC);
         check({t, " reset imm"}, imm, 0);
         check({t, " reset regSel"}, regSel, 0);
         check({t, " reset halted"}, halted, 0);
         check_ctrl({t, " reset"}, 0, 0, 0, 0);
         tick();
         check({t, " decode progAddr"}, progAddr, RPC + 8'd1);
         check({t, " decode imm"}, imm, vecs[i].instr[3:0]);
         check({t, " decode regSel"}, regSel, vecs[i].instr[3:0]);
         check_ctrl({t, " decode"}, 0, 0, 0, 0);
         tick();
         check_ctrl({t, " exec"}, vecs[i].load, vecs[i].sel, vecs[i].alu, vecs[i].rw);
         tick();
         check({t, " next progAddr"}, progAddr, vecs[i].next_pc);
         check({t, " next halted"}, halted, vecs[i].halt);
         check_ctrl({t, " next"}, 0, 0, 0, 0);
      end

      // HLT: stays halted with PC frozen, then a single run pulse resumes.
      prog[RPC] = 8'hF0;
      prog[RPC + 8'd1] = 8'h00;
      do_reset();
      tick();
      tick();
      tick();
      for (int h = 0; h < 10; h++) begin
         check("halt halted", halted, 1);
         check("halt progAddr", progAddr, RPC + 8'd1);
         check("halt LoadAcc", LoadAcc, 0);
         tick();
      end
      run = 1'b1;
      tick();
      run = 1'b0;
      check("resume halted", halted, 0);
      check("resume progAddr", progAddr, RPC + 8'd1);
      tick();
      check("resume decode progAddr", progAddr, RPC + 8'd2);

      // run held high: one fetch per HALT exit.
      prog[RPC] = 8'hF0;
      prog[RPC + 8'd1] = 8'hF0;
      run = 1'b1;
      do_reset();
      tick();
      tick();
      tick();
      check("runhigh halt1", halted, 1);
      check("runhigh halt1 pc", progAddr, RPC + 8'd1);
      tick();
      check("runhigh fetch halted", halted, 0);
      check("runhigh fetch pc", progAddr, RPC + 8'd1);
      tick();
      tick();
      tick();
      check("runhigh halt2", halted, 1);
      check("runhigh halt2 pc", progAddr, RPC + 8'd2);
      run = 1'b0;

      // PC wrap: jump to 8'hFF, NOP there, next fetch at 8'h00.
      prog[RPC] = 8'h90;
      prog[8'hFF] = 8'h00;
      forced_acc = 8'hFF;
      do_reset();
      tick();
      tick();
      tick();
      check("wrap fetch pc", progAddr, 8'hFF);
      tick();
      check("wrap decode pc", progAddr, 8'h00);

      // Reset asserted during EXEC of ADD.
      prog[RPC] = 8'h42;
      forced_acc = 8'h00;
      do_reset();
      tick();
      tick();
      check("rst-exec LoadAcc before", LoadAcc, 1);
      CLB = 1'b1;
      tick();
      CLB = 1'b0;
      check("rst-exec LoadAcc", LoadAcc, 0);
      check("rst-exec SelAcc", SelAcc, 0);
      check("rst-exec progAddr", progAddr, RPC);
      check("rst-exec halted", halted, 0);
      tick();
      check("rst-exec decode progAddr", progAddr, RPC + 8'd1);

      // Random program against the instruction-level model.
      for (int i = 0; i < 256; i++) prog[i] = 8'($urandom);
      env_en = 1'b1;
      do_reset();
      m_pc = RPC;
      m_acc = 8'h00;
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;

      for (int k = 0; k < 300; k++) begin
         logic [7:0] instr, nxt;
         logic [3:0] op, n;
         logic       e_load, e_rw;
         logic [1:0] e_sel;
         logic [2:0] e_alu;
         instr = prog[m_pc];
         op = instr[7:4];
         n = instr[3:0];
         run = 1'($urandom_range(0, 1));
         check("rnd fetch pc", progAddr, m_pc);
         check("rnd fetch halted", halted, 0);
         check_ctrl("rnd fetch", 0, 0, 0, 0);
         tick();
         run = 1'($urandom_range(0, 1));
         check("rnd decode pc", progAddr, m_pc + 8'd1);
         check("rnd decode imm", imm, n);
         check_ctrl("rnd decode", 0, 0, 0, 0);
         tick();
         run = 1'($urandom_range(0, 1));
         e_load = (op == 4'h1) || (op == 4'h2) || (op >= 4'h4 && op <= 4'h8);
         e_rw   = (op == 4'h3);
         e_sel  = (op == 4'h2) ? 2'b01 : (op >= 4'h4 && op <= 4'h8) ? 2'b10 : 2'b00;
         e_alu  = (op >= 4'h4 && op <= 4'h8) ? 3'(op - 4'h4) : 3'b000;
         check("rnd exec Acc", Acc, m_acc);
         check("rnd exec regSel", regSel, n);
         check_ctrl($sformatf("rnd exec op%0h", op), e_load, e_sel, e_alu, e_rw);

         nxt = m_pc + 8'd1;
         case (op)
            4'h1: m_acc = {4'b0, n};
            4'h2: m_acc = m_regs[n];
            4'h3: m_regs[n] = m_acc;
            4'h4: m_acc = m_acc + m_regs[n];
            4'h5: m_acc = m_acc - m_regs[n];
            4'h6: m_acc = m_acc & m_regs[n];
            4'h7: m_acc = m_acc | m_regs[n];
            4'h8: m_acc = m_acc ^ m_regs[n];
            4'h9: nxt = m_acc;
            4'hA: if (m_acc == 8'h00) nxt = m_acc;
            default: ;
         endcase
         m_pc = nxt;
         tick();

         if (op == 4'hF) begin
            for (int h = 0; h < 20; h++) begin
               logic r;
               check("rnd halt halted", halted, 1);
               check("rnd halt pc", progAddr, m_pc);
               r = (h == 19) ? 1'b1 : ($urandom_range(0, 2) == 0);
               run = r;
               tick();
               if (r) break;
            end
         end
      end
      run = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/acc_control_unit.md
# acc_control_unit

Fetch/decode/execute sequencer for the 8-bit microprocessor datapath. Reads 8-bit instructions from program memory and drives the accumulator controls, register-file select/write, and ALU operation select:
- accumulator controls: `LoadAcc`, `SelAcc`, `imm`
- register file: `regSel`, `regWrite`
- ALU: `aluOp`

It owns the program counter and instruction register, and is the only block that commands accumulator loads.

## Interface
Parameters:
- `RESET_PC`, default 8'h00: program counter value loaded on reset.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `CLB`, in, 1: reset, synchronous, active-high.
- `run`, in, 1: resume from HALT; sampled only in HALT.
- `progData`, in, 8: instruction word from combinational program memory at `progAddr`.
- `Acc`, in, 8: current accumulator value; used as jump target and for zero test.
- `progAddr`, out, 8: program counter value.
- `LoadAcc`, out, 1: accumulator load enable.
- `SelAcc`, out, 2: accumulator source select.
  - 00 = `{4'b0, imm}`
  - 01 = register value
  - 1x = ALU result
- `imm`, out, 4: IR[3:0].
- `regSel`, out, 4: IR[3:0]; register file read/write index.
- `regWrite`, out, 1: register file write enable; writes `Acc` into `R[regSel]`.
- `aluOp`, out, 3: ALU function select.
- `halted`, out, 1: high while in HALT.

## Operation
Instruction format: opcode = IR[7:4], operand n = IR[3:0].

Opcodes:
- 0 NOP: no action.
- 1 LDI: Acc ← n. SelAcc = 00.
- 2 MOV: Acc ← R[n]. SelAcc = 01.
- 3 STR: R[n] ← Acc. `regWrite` = 1.
- 4–8, SelAcc = 10, `LoadAcc` = 1:
  - 4 ADD: `aluOp` = 000.
  - 5 SUB: `aluOp` = 001.
  - 6 AND: `aluOp` = 010.
  - 7 OR: `aluOp` = 011.
  - 8 XOR: `aluOp` = 100.
- 9 JMP: PC ← Acc.
- A JZ: PC ← Acc if Acc == 8'h00, else no action.
- F HLT: enter HALT.
- B–E: treated as NOP.

State machine, 2-bit state:
- FETCH → DECODE: IR ← `progData`; PC ← PC + 1, wrapping 8'hFF → 8'h00.
- DECODE → EXEC: no outputs asserted.
- EXEC → FETCH, or → HALT for HLT.
  - All datapath controls are asserted for exactly this one cycle.
  - JMP/JZ PC update occurs on the EXEC→FETCH edge and overrides the FETCH increment.
- HALT → HALT while `run` = 0; HALT → FETCH when `run` = 1. PC is not modified in HALT.

Output rules:
- Outputs are decoded from registered state and IR only, so they are glitch-free within a cycle.
- Outside EXEC: `LoadAcc` = 0, `regWrite` = 0, `SelAcc` = 00, `aluOp` = 000.
- `imm` and `regSel` always reflect IR[3:0].
- `LoadAcc` and `regWrite` are never both high.

## Timing
- Reset with `CLB` = 1 at an edge gives, in the next cycle:
  - state = FETCH, PC = `RESET_PC`, IR = 8'h00
  - `progAddr` = `RESET_PC`
  - `LoadAcc` = 0, `regWrite` = 0, `SelAcc` = 00, `aluOp` = 000, `imm` = 0, `regSel` = 0, `halted` = 0
- Reset wins over every state, including EXEC; no EXEC-cycle control is issued in the reset cycle's successor.
- Every instruction takes 3 cycles (FETCH, DECODE, EXEC). `progAddr` = PC during all cycles.
- `progData` must be valid in the FETCH cycle; it is captured at the end of FETCH.
- Accumulator and register writes land at the end of the EXEC edge. The next instruction's EXEC sees the updated `Acc`.
- JZ zero test uses `Acc` sampled in EXEC.
- HLT: `halted` = 1 starting the cycle after EXEC.
  - `run` = 1 in a HALT cycle gives FETCH next cycle, `halted` = 0.
  - `run` held high continuously: one instruction fetch per HALT exit, no skipping.
- `run` outside HALT is ignored.

## Test plan
- Reset: hold `CLB` = 1 for 2 cycles with `RESET_PC` = 8'h10, then release.
  - `progAddr` = 8'h10, all controls 0.
  - First FETCH reads 8'h10.
- LDI 5 (8'h15) at 0x00:
  - `LoadAcc` = 1, `SelAcc` = 00, `imm` = 5 in cycle 3 only.
  - `progAddr` = 0x01 from cycle 2.
- Program LDI 3; STR 2; ADD 2 (8'h13, 8'h32, 8'h42):
  - `regWrite` = 1 with `regSel` = 2 in cycle 6.
  - `LoadAcc` = 1, `SelAcc` = 10, `aluOp` = 000 in cycle 9.
- JZ with Acc = 8'h00 → next `progAddr` = 8'h00. JZ with Acc = 8'h07 → PC+1. JMP with Acc = 8'h80 → `progAddr` = 8'h80.
- HLT at 0x05:
  - `halted` = 1, `progAddr` stays 0x06 for 10 cycles.
  - `run` pulse → FETCH at 0x06.
- NOP at PC = 8'hFF: `progAddr` wraps to 8'h00.
- `CLB` asserted during EXEC of ADD: `LoadAcc` low next cycle, state = FETCH at `RESET_PC`.
